// File: rtl/clk_en_gen.sv
// clk_en_gen: per-channel clock-enable pulse generator gated by a lock/settle FSM.
// Define CLK_EN_GEN_TOGGLE_EN to add per-channel 50%-duty tgl square waves.
module clk_en_gen #(
   parameter int NUM_CH      = 5,
   parameter int DIV_W       = 8,
   parameter int LOCK_CYCLES = 16,
   parameter int DEF_DIV     = 1
) (
   input  logic                    refclk,
   input  logic                    rst,
   input  logic [NUM_CH*DIV_W-1:0] div_i,
   input  logic                    cfg_we,
   input  logic [NUM_CH-1:0]       ch_en,
   output logic [NUM_CH-1:0]       cen,
   output logic [NUM_CH-1:0]       tgl,
   output logic                    locked
);

   localparam int LCW = $clog2(LOCK_CYCLES);

   typedef enum logic {
      SETTLE = 1'b0,
      RUN    = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [LCW-1:0]   r_lock_cnt;
   logic [DIV_W-1:0] r_div [NUM_CH];
   logic [DIV_W-1:0] r_cnt [NUM_CH];
   logic             w_lock_done;
   logic             w_run;

   assign w_lock_done = (r_lock_cnt == LCW'(LOCK_CYCLES - 1));
   assign w_run       = (r_state == RUN);

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state <= SETTLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (1'b1)
         cfg_we:                          w_state_nxt = SETTLE;
         (r_state == SETTLE) && w_lock_done: w_state_nxt = RUN;
         default:                         w_state_nxt = r_state;
      endcase
   end

   always_comb begin
      locked = (r_state == RUN);
   end

   // Counter only runs in SETTLE; it is parked at 0 in RUN so re-entry starts clean.
   always_ff @(posedge refclk) begin
      if (rst || cfg_we || w_run || w_lock_done) begin
         r_lock_cnt <= '0;
      end else begin
         r_lock_cnt <= r_lock_cnt + LCW'(1);
      end
   end

   always_ff @(posedge refclk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            r_div[i] <= DIV_W'(DEF_DIV);
            r_cnt[i] <= '0;
         end else begin
            if (cfg_we) begin
               r_div[i] <= div_i[i*DIV_W +: DIV_W];
            end
            if (cfg_we || !w_run || !ch_en[i] || cen[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + DIV_W'(1);
            end
         end
      end
   end

   always_comb begin
      cen = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cen[i] = w_run && ch_en[i] && (r_cnt[i] == r_div[i]);
      end
   end

`ifdef CLK_EN_GEN_TOGGLE_EN
   logic [NUM_CH-1:0] r_tgl;

   // SETTLE is only entered through rst/cfg_we, so clearing here keeps tgl low there.
   always_ff @(posedge refclk) begin
      if (rst || cfg_we) begin
         r_tgl <= '0;
      end else begin
         r_tgl <= r_tgl ^ cen;
      end
   end

   assign tgl = r_tgl;
`else
   assign tgl = '0;
`endif

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed bench for clk_en_gen with a cycle-level arithmetic model.
// Honours CLK_EN_GEN_TOGGLE_EN for the tgl expectations.
module tb_clk_en_gen;

   localparam int NCH  = 5;
   localparam int DW   = 8;
   localparam int LC   = 16;
   localparam int DEFD = 1;

   logic              refclk = 1'b0;
   logic              rst;
   logic [NCH*DW-1:0] div_i;
   logic              cfg_we;
   logic [NCH-1:0]    ch_en;
   logic [NCH-1:0]    cen;
   logic [NCH-1:0]    tgl;
   logic              locked;

   always #5 refclk = ~refclk;

   clk_en_gen #(
      .NUM_CH      (NCH),
      .DIV_W       (DW),
      .LOCK_CYCLES (LC),
      .DEF_DIV     (DEFD)
   ) dut (
      .refclk (refclk),
      .rst    (rst),
      .div_i  (div_i),
      .cfg_we (cfg_we),
      .ch_en  (ch_en),
      .cen    (cen),
      .tgl    (tgl),
      .locked (locked)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model: edges since last rst/cfg_we, and per-channel running age.
   bit m_valid = 1'b0;
   int m_since = 0;
   int m_div [NCH];
   int m_age [NCH];
   bit m_tgl [NCH];
   int mf [NCH];
   int mp [NCH];

   function automatic bit m_locked();
      return m_valid && (m_since >= LC);
   endfunction

   function automatic bit m_cen(input int i);
      return m_locked() && ch_en[i] && ((m_age[i] % (m_div[i] + 1)) == m_div[i]);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      bit               c [NCH];
      logic [NCH-1:0]   ec;
      logic [NCH-1:0]   et;
      @(posedge refclk);
      for (int i = 0; i < NCH; i++) c[i] = m_cen(i);
      for (int i = 0; i < NCH; i++) begin
         if (rst) begin
            m_div[i] = DEFD;
            m_age[i] = 0;
            m_tgl[i] = 1'b0;
         end else if (cfg_we) begin
            m_div[i] = int'(div_i[i*DW +: DW]);
            m_age[i] = 0;
            m_tgl[i] = 1'b0;
         end else begin
            if (c[i]) m_tgl[i] = ~m_tgl[i];
            m_age[i] = (m_locked() && ch_en[i]) ? m_age[i] + 1 : 0;
         end
      end
      if (rst) m_valid = 1'b1;
      if (rst || cfg_we) m_since = 0;
      else if (m_since < 1000) m_since++;
      @(negedge refclk);
      if (m_valid) begin
         for (int i = 0; i < NCH; i++) begin
            ec[i] = m_cen(i);
`ifdef CLK_EN_GEN_TOGGLE_EN
            et[i] = m_tgl[i];
`else
            et[i] = 1'b0;
`endif
         end
         chk("locked", {31'd0, locked}, {31'd0, m_locked()});
         chk("cen", {27'd0, cen}, {27'd0, ec});
         chk("tgl", {27'd0, tgl}, {27'd0, et});
      end
   endtask

   task automatic wait_lock(input string nm);
      int             k;
      logic [NCH-1:0] acc;
      k   = 0;
      acc = '0;
      while (!locked && k < 40) begin
         acc |= cen;
         cyc();
         k++;
      end
      chk(nm, k, 16);
      chk({nm, "_settle_cen"}, {27'd0, acc}, 0);
   endtask

   task automatic measure(input int n);
      int last [NCH];
      for (int i = 0; i < NCH; i++) begin
         mf[i]   = -1;
         mp[i]   = -1;
         last[i] = -1;
      end
      for (int t = 0; t < n; t++) begin
         if (t > 0) cyc();
         for (int i = 0; i < NCH; i++) begin
            if (cen[i]) begin
               if (mf[i] < 0) mf[i] = t;
               if (last[i] >= 0) mp[i] = t - last[i];
               last[i] = t;
            end
         end
      end
   endtask

   task automatic set_div(input int a, input int b, input int c,
                          input int d, input int e);
      int v [NCH];
      v = '{a, b, c, d, e};
      for (int i = 0; i < NCH; i++) div_i[i*DW +: DW] = DW'(v[i]);
   endtask

   initial begin
      int pexp [NCH];
      int acc;
      int k;
      int hi;
      int bad;
      bit s [16];

      pexp = '{1, 2, 4, 7, 256};
      rst    = 1'b1;
      cfg_we = 1'b0;
      ch_en  = '1;
      div_i  = '0;
      repeat (3) cyc();
      chk("rst_locked", {31'd0, locked}, 0);
      chk("rst_cen", {27'd0, cen}, 0);
      chk("rst_tgl", {27'd0, tgl}, 0);

      rst = 1'b0;
      wait_lock("release_lock");

      set_div(0, 1, 3, 6, 255);
      cfg_we = 1'b1;
      cyc();
      cfg_we = 1'b0;
      wait_lock("cfg1_lock");
      measure(600);
      chk("cfg1_ch2_first", mf[2], 3);
      for (int i = 0; i < NCH; i++)
         chk($sformatf("cfg1_period_ch%0d", i), mp[i], pexp[i]);

      set_div(4, 3, 3, 6, 255);
      cfg_we = 1'b1;
      cyc();
      cfg_we = 1'b0;
      chk("cfg2_locked_low", {31'd0, locked}, 0);
      wait_lock("cfg2_lock");
      measure(40);
      chk("cfg2_ch0_first", mf[0], 4);
      chk("cfg2_ch0_period", mp[0], 5);
      chk("cfg2_ch1_first", mf[1], 3);
      chk("cfg2_ch2_first", mf[2], 3);

      ch_en[1] = 1'b0;
      acc = 0;
      repeat (10) begin
         cyc();
         acc += int'(cen[1]);
      end
      chk("gap_cen1", acc, 0);
      ch_en[1] = 1'b1;
      k = 0;
      do begin
         cyc();
         k++;
      end while (!cen[1] && k < 20);
      chk("reen_first", k, 3);

      set_div(9, 9, 9, 9, 9);
      rst    = 1'b1;
      cfg_we = 1'b1;
      cyc();
      rst    = 1'b0;
      cfg_we = 1'b0;
      chk("rstcfg_locked", {31'd0, locked}, 0);
      chk("rstcfg_cen", {27'd0, cen}, 0);
      wait_lock("rstcfg_lock");
      measure(20);
      chk("rstcfg_ch0_period", mp[0], 2);

      hi  = 0;
      bad = 0;
      for (int t = 0; t < 16; t++) begin
         cyc();
         s[t] = tgl[0];
         hi  += int'(tgl[0]);
      end
`ifdef CLK_EN_GEN_TOGGLE_EN
      for (int t = 0; t < 12; t++)
         if (s[t] != s[t+4] || s[t] == s[t+2]) bad++;
      chk("tgl_high", hi, 8);
      chk("tgl_shape", bad, 0);
`else
      chk("tgl_high", hi, 0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
